// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and line levels for the UART transmit path
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;
  localparam logic STOP_LEVEL    = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, pulses tick on the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == LAST;
  always_comb cnt_d = (clear || tick) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: byte-to-serial UART frame generator (start, data LSB first, stop).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_framer: unsupported parameter combination");
  end
  tx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic stop_q, stop_d, tx_q, tx_d, done_q, done_d, tick, accept;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  assign tx_ready = state_q == IDLE;
  assign busy     = !tx_ready;
  assign tx       = tx_q;
  assign done     = done_q;
  assign accept   = tx_valid && tx_ready;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        sh_d    = tx_data;
        bit_d   = '0;
        stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^tx_data ^ 1'(PARITY_ODD);
`endif
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + BW'(1);
`ifdef UART_TX_PARITY_EN
        if (bit_q == LAST_BIT) state_d = PARITY;
`else
        if (bit_q == LAST_BIT) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) begin
        stop_d = stop_q + 1'b1;
        if (stop_q == LAST_STOP) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the next state so the line changes exactly on bit boundaries
    tx_d = state_d == START ? START_LEVEL :
           state_d == DATA  ? sh_d[0]     :
           state_d == STOP  ? STOP_LEVEL  : TX_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    if (state_d == PARITY) tx_d = par_d;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= TX_IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) par_q <= reset ? 1'b0 : par_d;
`endif
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;
  localparam int CPB = 4;
  localparam int DB = 8;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int P = 1;
`else
  localparam int SB = 1;
  localparam int P = 0;
`endif
  localparam int NB = 1 + DB + P + SB;
  logic clk = 1'b0, reset = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx, busy, done;
  int nchk = 0, nerr = 0, ndone = 0, d0 = 0;
  uart_tx_framer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (done === 1'b1) ndone++;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // bit k of the result is the line level during bit k of the frame
  function automatic logic [12:0] frame(input logic [7:0] d, input logic p);
    frame = (P != 0) ? {1'b1, 2'b11, p, d, 1'b0} : {4'b1111, d, 1'b0};
  endfunction
  task automatic idle_chk(input string tag);
    chk({tag, "_tx"}, tx, 1);
    chk({tag, "_ready"}, tx_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  // called in the acceptance cycle; returns in the done cycle
  task automatic run_frame(input string tag, input logic [12:0] f, input logic hold,
                           input logic [7:0] next_d, input int poke);
    chk({tag, "_ready"}, tx_ready, 1);
    step();
    if (!hold) tx_valid = 1'b0;
    tx_data = next_d;
    chk({tag, "_start_lat"}, tx, 0);
    chk({tag, "_busy"}, busy, 1);
    for (int c = 1; c <= NB * CPB; c++) begin
      if (c % CPB == 2) chk($sformatf("%s_bit%0d", tag, c / CPB), tx, f[c/CPB]);
      if (c % CPB == 0) chk($sformatf("%s_nodone%0d", tag, c), done, 0);
      if (poke > 0 && c == poke) begin
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
      end
      if (poke > 0 && c == poke + 1) tx_valid = 1'b0;
      step();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_ready"}, tx_ready, 1);
    chk({tag, "_done_tx"}, tx, 1);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      step();
      idle_chk("rst");
    end
    reset = 1'b0;
    step();
    idle_chk("post_rst");
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    run_frame("a5", frame(8'hA5, 1'(PODD)), 1'b0, 8'hA5, 0);
    step();
    chk("a5_ndone", ndone, 1);
    idle_chk("a5_after");
    d0       = ndone;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    run_frame("b00", frame(8'h00, 1'(PODD)), 1'b1, 8'hFF, 0);
    run_frame("bff", frame(8'hFF, 1'(PODD)), 1'b0, 8'hFF, 0);
    step();
    chk("b2b_ndone", ndone - d0, 2);
    d0       = ndone;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    run_frame("ign", frame(8'h5A, 1'(PODD)), 1'b0, 8'h5A, 10);
    for (int i = 0; i < 6; i++) step();
    idle_chk("ign_after");
    chk("ign_ndone", ndone - d0, 1);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = 1; i < 18; i++) step();
    chk("mid_bit3", tx, 0);
    chk("mid_busy", busy, 1);
    d0    = ndone;
    reset = 1'b1;
    step();
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) step();
    idle_chk("abort_after");
    chk("abort_ndone", ndone - d0, 0);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    run_frame("r81", frame(8'h81, 1'(PODD)), 1'b0, 8'h81, 0);
    step();
`ifdef UART_TX_PARITY_EN
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    run_frame("par07", frame(8'h07, 1'b1 ^ 1'(PODD)), 1'b0, 8'h07, 0);
    step();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
